// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset controller:
// opcode/func fields, ALU operation codes, state encoding, mux encodings.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNC_ADD = 6'b100000;
   localparam logic [5:0] FUNC_SUB = 6'b100010;
   localparam logic [5:0] FUNC_AND = 6'b100100;
   localparam logic [5:0] FUNC_OR  = 6'b100101;
   localparam logic [5:0] FUNC_SLT = 6'b101010;
   localparam logic [5:0] FUNC_NOP = 6'b000000;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   typedef enum logic [3:0] {
      S_IDLE      = 4'hF,
      S_FETCH     = 4'h0,
      S_DECODE    = 4'h1,
      S_MEM_ADDR  = 4'h2,
      S_MEM_RD    = 4'h3,
      S_MEM_WB    = 4'h4,
      S_MEM_WR    = 4'h5,
      S_R_EXEC    = 4'h6,
      S_R_WB      = 4'h7,
      S_BRANCH    = 4'h8,
      S_JUMP      = 4'h9,
      S_ADDI_EXEC = 4'hA,
      S_ADDI_WB   = 4'hB
   } state_e;

   typedef enum logic [1:0] {
      SRCB_REGB    = 2'd0,
      SRCB_FOUR    = 2'd1,
      SRCB_IMM     = 2'd2,
      SRCB_IMM_SH2 = 2'd3
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_ALUOUT = 2'd1,
      PCSRC_JUMP   = 2'd2
   } pc_source_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between instruction register / memory handshake and the controller
// strobes. master = IR/memory side, slave = controller.
interface multicycle_control_fsm_if #(
   parameter int unsigned CNT_W = 32
);
   logic [5:0]       op_in;
   logic [5:0]       func_in;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic             i_or_d;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             mem_to_reg;
   logic             reg_dst;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       pc_source;
   logic [3:0]       alu_cntrl;
   logic             illegal_op;
   logic [3:0]       state_out;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output op_in, func_in, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
             alu_cntrl, illegal_op, state_out, instr_count
   );

   modport slave (
      input  op_in, func_in, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
             alu_cntrl, illegal_op, state_out, instr_count
   );
endinterface

// File: rtl/multicycle_control_fsm_alu_func_decode.sv
// R-type function field to ALU operation; valid_o is low for unsupported funcs.
module alu_func_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] func_i,
   output logic [3:0] alu_cntrl_o,
   output logic       valid_o
);

   always_comb begin
      alu_cntrl_o = ALU_PASS;
      valid_o     = 1'b1;
      unique case (func_i)
         FUNC_ADD: alu_cntrl_o = ALU_ADD;
         FUNC_SUB: alu_cntrl_o = ALU_SUB;
         FUNC_AND: alu_cntrl_o = ALU_AND;
         FUNC_OR:  alu_cntrl_o = ALU_OR;
         FUNC_SLT: alu_cntrl_o = ALU_SLT;
         default:  valid_o     = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the shared-ALU multi-cycle datapath; stalls
// on mem_ready in memory states and counts retired instructions.
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   multicycle_control_fsm_if.slave   bus
);

   state_e           state_q, state_d;
   logic             is_sw_q, is_sw_d;
   logic [CNT_W-1:0] count_q;
   logic             retire;
   logic             func_valid;
   logic [3:0]       r_alu;

   alu_func_decode u_func_dec (
      .func_i      (bus.func_in),
      .alu_cntrl_o (r_alu),
      .valid_o     (func_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         is_sw_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         is_sw_q <= is_sw_d;
         if (retire) count_q <= count_q + 1'b1;
      end
   end

   always_comb begin
      state_d           = state_q;
      is_sw_d           = is_sw_q;
      retire            = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = SRCB_REGB;
      bus.pc_source     = PCSRC_ALU;
      bus.alu_cntrl     = ALU_PASS;
      bus.illegal_op    = 1'b0;

      unique case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = SRCB_FOUR;
            bus.alu_cntrl = ALU_ADD;
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_d      = S_DECODE;
            end
         end

         S_DECODE: begin
            bus.alu_src_b = SRCB_IMM_SH2;
            bus.alu_cntrl = ALU_ADD;
            state_d       = S_FETCH;
            // LW/SW choice is latched here so MEM_ADDR never looks at op_in.
            unique case (bus.op_in)
               OP_LW:   begin state_d = S_MEM_ADDR; is_sw_d = 1'b0; end
               OP_SW:   begin state_d = S_MEM_ADDR; is_sw_d = 1'b1; end
               OP_BEQ:  state_d = S_BRANCH;
               OP_J:    state_d = S_JUMP;
               OP_ADDI: state_d = S_ADDI_EXEC;
               OP_RTYPE: begin
                  if (bus.func_in == FUNC_NOP) retire = 1'b1;
                  else if (func_valid)         state_d = S_R_EXEC;
                  else                         bus.illegal_op = 1'b1;
               end
               default: bus.illegal_op = 1'b1;
            endcase
         end

         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_cntrl = ALU_ADD;
            state_d       = is_sw_q ? S_MEM_WR : S_MEM_RD;
         end

         S_MEM_RD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
            if (bus.mem_ready) state_d = S_MEM_WB;
         end

         S_MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            retire         = 1'b1;
            state_d        = S_FETCH;
         end

         S_MEM_WR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end

         S_R_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_cntrl = r_alu;
            state_d       = S_R_WB;
         end

         S_R_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH;
         end

         S_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_cntrl     = ALU_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = PCSRC_ALUOUT;
            retire            = 1'b1;
            state_d           = S_FETCH;
         end

         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PCSRC_JUMP;
            retire        = 1'b1;
            state_d       = S_FETCH;
         end

         S_ADDI_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_cntrl = ALU_ADD;
            state_d       = S_ADDI_WB;
         end

         S_ADDI_WB: begin
            bus.reg_write = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.state_out   = state_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: per-instruction expansion into expected per-cycle outputs,
// checked mid-cycle by an independent monitor.
module tb_multicycle_control_fsm;

   localparam int unsigned CW = 4;

   typedef struct packed {
      logic [3:0]    st;
      logic          pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
      logic [1:0]    asb, psrc;
      logic [3:0]    alu;
      logic          ill;
      logic [CW-1:0] cnt;
   } outs_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_control_fsm_if #(.CNT_W(CW)) bus ();
   multicycle_control_fsm #(.CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   outs_t exp_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    mcount = 0;

   function automatic outs_t base(input logic [3:0] st);
      outs_t e;
      e     = '0;
      e.st  = st;
      e.alu = 4'hF;
      e.cnt = mcount[CW-1:0];
      return e;
   endfunction

   function automatic outs_t sample();
      outs_t a;
      a.st   = bus.state_out;     a.pw   = bus.pc_write;
      a.pwc  = bus.pc_write_cond; a.iord = bus.i_or_d;
      a.mr   = bus.mem_read;      a.mw   = bus.mem_write;
      a.irw  = bus.ir_write;      a.m2r  = bus.mem_to_reg;
      a.rdst = bus.reg_dst;       a.rw   = bus.reg_write;
      a.asa  = bus.alu_src_a;     a.asb  = bus.alu_src_b;
      a.psrc = bus.pc_source;     a.alu  = bus.alu_cntrl;
      a.ill  = bus.illegal_op;    a.cnt  = bus.instr_count;
      return a;
   endfunction

   // One clock of stimulus: inputs change just after the edge, expectation queued.
   task automatic step(input outs_t e, input logic rdy);
      @(posedge clk);
      #1;
      bus.mem_ready = rdy;
      exp_q.push_back(e);
   endtask

   function automatic logic rnd_bit();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic do_reset(input int unsigned cyc);
      for (int unsigned i = 0; i < cyc; i++) begin
         @(posedge clk);
         #1;
         reset_n       = 1'b0;
         bus.mem_ready = 1'b0;
         mcount        = 0;
         exp_q.push_back(base(4'hF));
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_q.push_back(base(4'hF));
   endtask

   // R-type func -> required ALU op; returns 0 when the func is unsupported.
   function automatic bit r_alu(input logic [5:0] f, output logic [3:0] code);
      code = 4'hF;
      case (f)
         6'b100000: code = 4'b0000;
         6'b100010: code = 4'b0001;
         6'b100100: code = 4'b0010;
         6'b100101: code = 4'b0101;
         6'b101010: code = 4'b0100;
         default:   return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic run_instr(input logic [5:0] op, input logic [5:0] func,
                            input int unsigned fst, input int unsigned mst,
                            input bit abort);
      outs_t       e;
      logic [3:0]  code;
      bit          rok;
      for (int unsigned i = 0; i <= fst; i++) begin
         e     = base(4'h0);
         e.mr  = 1'b1; e.asb = 2'd1; e.alu = 4'h0;
         if (i == fst) begin e.irw = 1'b1; e.pw = 1'b1; end
         @(posedge clk);
         #1;
         if (i == 0) begin bus.op_in = op; bus.func_in = func; end
         bus.mem_ready = (i == fst);
         exp_q.push_back(e);
      end
      e = base(4'h1); e.asb = 2'd3; e.alu = 4'h0;
      rok = r_alu(func, code);
      case (op)
         6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000: ;
         6'b000000: begin
            if (func == 6'b000000) begin
               step(e, rnd_bit());
               mcount++;
               return;
            end
            if (!rok) e.ill = 1'b1;
         end
         default: e.ill = 1'b1;
      endcase
      step(e, rnd_bit());
      if (e.ill) return;

      case (op)
         6'b100011, 6'b101011: begin
            e = base(4'h2); e.asa = 1'b1; e.asb = 2'd2; e.alu = 4'h0;
            step(e, rnd_bit());
            for (int unsigned i = 0; i <= mst; i++) begin
               if (abort && i == 2) begin
                  do_reset(1);
                  return;
               end
               e = base(op == 6'b100011 ? 4'h3 : 4'h5);
               e.iord = 1'b1;
               if (op == 6'b100011) e.mr = 1'b1; else e.mw = 1'b1;
               step(e, i == mst);
            end
            if (op == 6'b100011) begin
               e = base(4'h4); e.rw = 1'b1; e.m2r = 1'b1;
               step(e, rnd_bit());
            end
         end
         6'b000000: begin
            e = base(4'h6); e.asa = 1'b1; e.asb = 2'd0; e.alu = code;
            step(e, rnd_bit());
            e = base(4'h7); e.rw = 1'b1; e.rdst = 1'b1;
            step(e, rnd_bit());
         end
         6'b000100: begin
            e = base(4'h8); e.asa = 1'b1; e.alu = 4'h1; e.pwc = 1'b1; e.psrc = 2'd1;
            step(e, rnd_bit());
         end
         6'b000010: begin
            e = base(4'h9); e.pw = 1'b1; e.psrc = 2'd2;
            step(e, rnd_bit());
         end
         default: begin
            e = base(4'hA); e.asa = 1'b1; e.asb = 2'd2; e.alu = 4'h0;
            step(e, rnd_bit());
            e = base(4'hB); e.rw = 1'b1;
            step(e, rnd_bit());
         end
      endcase
      mcount++;
   endtask

   function automatic bit legal_op(input logic [5:0] o);
      return o inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
   endfunction

   initial begin : monitor
      outs_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL cycle_outputs t=%0t state act=%h exp=%h | outputs act=%h required=%h",
                        $time, a.st, e.st, a, e);
            end
         end
      end
   end

   initial begin : stimulus
      logic [5:0]  op, fn;
      logic [3:0]  dummy;
      int unsigned kind, w;
      bus.op_in     = '0;
      bus.func_in   = '0;
      bus.mem_ready = 1'b0;

      do_reset(2);
      run_instr(6'b100011, 6'b010101, 0, 0, 0);   // LW
      run_instr(6'b101011, 6'b000000, 0, 3, 0);   // SW, 3 stall cycles
      run_instr(6'b000000, 6'b100010, 0, 0, 0);   // SUB
      run_instr(6'b000000, 6'b101010, 0, 0, 0);   // SLT
      run_instr(6'b111111, 6'b000000, 0, 0, 0);   // illegal op
      run_instr(6'b000000, 6'b000111, 0, 0, 0);   // illegal func
      run_instr(6'b000000, 6'b000000, 0, 0, 0);   // NOP
      run_instr(6'b100011, 6'b000000, 1, 5, 1);   // reset during MEM_RD wait
      run_instr(6'b000100, 6'b000000, 0, 0, 0);   // BEQ
      run_instr(6'b000010, 6'b000000, 0, 0, 0);   // J
      run_instr(6'b001000, 6'b000000, 2, 0, 0);   // ADDI with fetch stall

      for (int n = 0; n < 160; n++) begin
         kind = $urandom_range(0, 9);
         fn   = 6'($urandom);
         case (kind)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000100;
            3: op = 6'b000010;
            4: op = 6'b001000;
            5: begin
               op = 6'b000000;
               case ($urandom_range(0, 4))
                  0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
                  3: fn = 6'b100101; default: fn = 6'b101010;
               endcase
            end
            6: begin op = 6'b000000; fn = 6'b000000; end
            7: begin
               op = 6'($urandom);
               while (legal_op(op)) op = 6'($urandom);
            end
            8: begin
               op = 6'b000000;
               while (fn == 6'b000000 || r_alu(fn, dummy)) fn = 6'($urandom);
            end
            default: op = 6'b000000;
         endcase
         run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 0);
      end

      w = 0;
      while (exp_q.size() > 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      if (exp_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

- Sequencing controller for the team's multi-cycle MIPS-subset datapath: fetch, decode, execute, memory and writeback share one ALU and one memory port.
- Replaces per-instruction combinational decode with a Moore state machine that emits per-cycle datapath strobes.
- Stalls on a single-bit memory-ready handshake and counts retired instructions.
- Sits between the instruction register (op/func fields) and the datapath muxes, register file, PC and memory.

## Interface

Parameters
- CNT_W, 32, width of retired-instruction counter

Ports
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op_in  in  6  opcode field from instruction register
- func_in  in  6  function field from instruction register
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (BEQ)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback select: 1 = MDR
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  0 = regB, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- alu_cntrl  out  4  ALU operation
- illegal_op  out  1  one-cycle pulse on unsupported opcode/func
- state_out  out  4  current state (debug)
- instr_count  out  CNT_W  retired-instruction count

## Operation

- Opcodes:
  - R-type 000000
  - ADDI 001000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
- R-type func codes:
  - ADD 100000
  - SUB 100010
  - AND 100100
  - OR 100101
  - SLT 101010
  - NOP = op 000000 with func 000000
- ALU codes:
  - ADD 0000
  - SUB 0001
  - AND 0010
  - SLT 0100
  - OR 0101
  - PASS/NOP 1111
- States (4-bit encoding):
  - IDLE=F
  - FETCH=0
  - DECODE=1
  - MEM_ADDR=2
  - MEM_RD=3
  - MEM_WB=4
  - MEM_WR=5
  - R_EXEC=6
  - R_WB=7
  - BRANCH=8
  - JUMP=9
  - ADDI_EXEC=A
  - ADDI_WB=B
- IDLE: all strobes 0; go to FETCH unconditionally.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, pc_source=0, alu_cntrl=ADD.
  - ir_write and pc_write assert only when mem_ready=1; otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_cntrl=ADD (branch target into ALUOut).
  - Dispatch: LW/SW→MEM_ADDR, R-type→R_EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDI_EXEC.
  - NOP→FETCH; counts as retired.
  - Any other op, or an unlisted R-type func: pulse illegal_op, go to FETCH, no retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; go to MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; retire.
- MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready; retire on the ready cycle.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_cntrl decoded from func.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; retire.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_source=1; retire.
- JUMP: pc_write=1, pc_source=2; retire.
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, ADD.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; retire.
- All retiring states except MEM_WR→FETCH; MEM_WR returns to FETCH only on its ready cycle.
- Outputs not listed for a state are 0; alu_cntrl default is 1111.
- instr_count: +1 on each retire, wraps modulo 2^CNT_W.
- op_in/func_in are sampled only in DECODE and R_EXEC; the IR holds them stable.

## Timing

- Reset (reset_n low, asynchronous):
  - state=IDLE, instr_count=0.
  - All strobes 0, alu_cntrl=1111, state_out=F.
- First FETCH is the first clock after reset_n deassertion.
- Cycles per instruction, zero wait:
  - LW 5
  - SW, R-type, ADDI 4
  - BEQ, J 3
  - NOP and illegal 2
- Each stalled cycle of mem_ready=0 adds one cycle in FETCH/MEM_RD/MEM_WR.
- Strobes are Moore outputs of the state register, except ir_write, pc_write (FETCH), which are gated by mem_ready.
- mem_ready outside memory states is ignored.
- mem_read/mem_write stay asserted and address-stable while waiting.
- Reset mid-instruction: immediate return to IDLE; a pending memory request drops the same cycle; no retire.

## Structure

- Shared package `mips_ctrl_pkg`:
  - opcode/func constants
  - ALU code constants
  - state enum typedef
  - alu_src_b / pc_source encodings
- Optional sub-module `alu_func_decode` (func_in → alu_cntrl, valid flag), reused by the single-cycle path.

## Test plan

- Reset release, mem_ready=1: state_out F→0→1; all strobes 0 during reset; instr_count=0.
- LW (op 100011), mem_ready=1: states 0,1,2,3,4; reg_write and mem_to_reg high in cycle 5; instr_count +1.
- SW with mem_ready low 3 cycles in MEM_WR: mem_write held 4 cycles, i_or_d=1 throughout; then FETCH; count +1.
- R-type SUB (func 100010): alu_cntrl=0001 in R_EXEC; reg_dst=1 and reg_write=1 next cycle. Same for SLT (101010) → 0100.
- Op 111111, then R-type func 000111: illegal_op pulses in DECODE each time; count unchanged; back to FETCH. NOP costs 2 cycles and counts +1.
- reset_n low during MEM_RD wait: state F within the same cycle; mem_read drops; count unchanged.
- BEQ: pc_write_cond=1, pc_source=1, alu_cntrl=0001 in cycle 3.
- J: pc_write=1, pc_source=2 in cycle 3.
